// File: rtl/divider.sv
// rtl/divider.sv - single-cycle unsigned restoring array divider, registered outputs.
// Define DIVIDER_REMAINDER_EN to add the registered remainder output.
module divider #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  valid,
  output logic                  div_by_zero
`ifdef DIVIDER_REMAINDER_EN
  ,
  output logic [DATA_WIDTH-1:0] remainder
`endif
);

  logic [DATA_WIDTH-1:0] quo_d;
  logic [DATA_WIDTH-1:0] rem_d;
  logic [DATA_WIDTH:0]   trial;
  logic [DATA_WIDTH:0]   diff;

  logic [DATA_WIDTH-1:0] result_q;
  logic                  valid_q;
  logic                  dbz_q;

  // One restoring stage per quotient bit, MSB first. With op2 == 0 every trial
  // succeeds, which yields an all-ones quotient and a remainder equal to op1.
  always_comb begin
    quo_d = '0;
    rem_d = '0;
    trial = '0;
    diff  = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      trial = {rem_d, op1[i]};
      diff  = trial - {1'b0, op2};
      if (trial >= {1'b0, op2}) begin
        quo_d[i] = 1'b1;
        rem_d    = diff[DATA_WIDTH-1:0];
      end else begin
        rem_d    = trial[DATA_WIDTH-1:0];
      end
    end
  end

`ifdef DIVIDER_REMAINDER_EN
  logic [DATA_WIDTH-1:0] rem_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q <= '0;
    end else if (enable) begin
      rem_q <= rem_d;
    end
  end

  assign remainder = rem_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      valid_q <= enable;
      if (enable) begin
        result_q <= quo_d;
        dbz_q    <= (op2 == '0);
      end
    end
  end

  assign result      = result_q;
  assign valid       = valid_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - scoreboard bench for divider at DATA_WIDTH=8.
module tb_divider;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [7:0] op1;
  logic [7:0] op2;
  logic [7:0] result;
  logic       valid;
  logic       div_by_zero;
`ifdef DIVIDER_REMAINDER_EN
  logic [7:0] remainder;
`endif

  divider #(.DATA_WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .op1         (op1),
    .op2         (op2),
    .result      (result),
    .valid       (valid),
    .div_by_zero (div_by_zero)
`ifdef DIVIDER_REMAINDER_EN
    ,
    .remainder   (remainder)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t x;
    if (b == 8'd0) begin
      x.q = 8'hff; x.r = a; x.z = 1'b1;
    end else begin
      x.q = a / b; x.r = a % b; x.z = 1'b0;
    end
    return x;
  endfunction

  // Drive one cycle of stimulus on the falling edge, sample 1 time unit after the rising edge.
  task automatic drive(input logic en, input logic [7:0] a, input logic [7:0] b);
    @(negedge clock);
    enable = en; op1 = a; op2 = b;
    if (en && !reset) sb.push_back(model(a, b));
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'd200, 8'd3);
      n_assert++;
      if (result !== 8'd0 || valid !== 1'b0 || div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: result=%0d valid=%b dbz=%b, want 0 0 0", result, valid, div_by_zero);
      end
`ifdef DIVIDER_REMAINDER_EN
      n_assert++;
      if (remainder !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_rem: got %0d want 0", remainder);
      end
`endif
    end
    reset = 1'b0;
  endtask

  task automatic test_table(input string name, input logic [15:0] pairs[$]);
    foreach (pairs[k]) begin
      drive(1'b1, pairs[k][15:8], pairs[k][7:0]);
      n_assert++;
      if (valid !== 1'b1 || sb.size() == 0) begin
        n_fail++;
        $display("FAIL %s_valid: op1=%0d op2=%0d valid=%b queued=%0d want valid 1", name,
                 pairs[k][15:8], pairs[k][7:0], valid, sb.size());
      end else begin
        e = sb.pop_front();
        n_assert++;
        if (result !== e.q || div_by_zero !== e.z) begin
          n_fail++;
          $display("FAIL %s_result: op1=%0d op2=%0d got q=%0d z=%b want q=%0d z=%b", name,
                   pairs[k][15:8], pairs[k][7:0], result, div_by_zero, e.q, e.z);
        end
`ifdef DIVIDER_REMAINDER_EN
        n_assert++;
        if (remainder !== e.r) begin
          n_fail++;
          $display("FAIL %s_rem: op1=%0d op2=%0d got %0d want %0d", name,
                   pairs[k][15:8], pairs[k][7:0], remainder, e.r);
        end
`endif
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] p[$];
    p = '{{8'd15, 8'd4}};
    test_table("basic", p);
  endtask

  task automatic test_sweep();
    logic [15:0] p[$];
    for (int b = 1; b <= 15; b++)
      for (int a = 0; a <= 15; a++)
        p.push_back({a[7:0], b[7:0]});
    test_table("sweep", p);
  endtask

  task automatic test_div_zero();
    logic [15:0] p[$];
    p = '{{8'd9, 8'd0}, {8'd9, 8'd9}, {8'd0, 8'd0}, {8'd255, 8'd0}, {8'd200, 8'd3}};
    test_table("divzero", p);
  endtask

  task automatic test_boundaries();
    logic [15:0] p[$];
    p = '{{8'd255, 8'd1}, {8'd7, 8'd255}, {8'd0, 8'd5}, {8'd3, 8'd8},
          {8'd200, 8'd200}, {8'd255, 8'd255}, {8'd254, 8'd255}, {8'd128, 8'd2}};
    test_table("boundary", p);
  endtask

  task automatic test_hold();
    logic [15:0] p[$];
    p = '{{8'd100, 8'd7}};
    test_table("hold_setup", p);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      n_assert++;
      if (valid !== 1'b0 || result !== 8'd14 || div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL hold: valid=%b result=%0d dbz=%b want 0 14 0", valid, result, div_by_zero);
      end
`ifdef DIVIDER_REMAINDER_EN
      n_assert++;
      if (remainder !== 8'd2) begin
        n_fail++;
        $display("FAIL hold_rem: got %0d want 2", remainder);
      end
`endif
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] p[$];
    reset = 1'b1;
    drive(1'b1, 8'd50, 8'd0);
    n_assert++;
    if (valid !== 1'b0 || result !== 8'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: valid=%b result=%0d dbz=%b want 0 0 0", valid, result, div_by_zero);
    end
    reset = 1'b0;
    drive(1'b0, 8'd50, 8'd5);
    n_assert++;
    if (valid !== 1'b0 || result !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: valid=%b result=%0d want 0 0", valid, result);
    end
    p = '{{8'd50, 8'd5}};
    test_table("post_reset", p);
  endtask

  task automatic test_back_to_back();
    logic [15:0] p[$];
    for (int i = 0; i < 40; i++)
      p.push_back({8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))});
    test_table("b2b", p);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; op1 = '0; op2 = '0;
    test_reset();
    test_basic();
    test_sweep();
    test_div_zero();
    test_boundaries();
    test_hold();
    test_reset_midstream();
    test_back_to_back();
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
